// File: rtl/inst_fetch_responder.sv
// inst_fetch_responder: single-line instruction fetch buffer that answers hits in one cycle
// and stalls fetch while refilling the line from a variable-latency memory read channel.
module inst_fetch_responder #(
   parameter int LINE_WORDS = 4
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        inst_sram_en,
   input  logic [3:0]  inst_sram_wen,
   input  logic [31:0] inst_sram_addr,
   input  logic [31:0] inst_sram_wdata,
   output logic [31:0] inst_sram_rdata,
   output logic        fetch_stall,
   input  logic        flush,
   output logic        mem_rd_req,
   output logic [31:0] mem_rd_addr,
   input  logic        mem_rd_ready,
   input  logic        mem_rd_valid,
   input  logic [31:0] mem_rd_data
);
   localparam int OW = $clog2(LINE_WORDS);
   localparam int TW = 30 - OW;
   localparam logic [OW:0] LAST_BEAT = (OW + 1)'(LINE_WORDS - 1);
   localparam logic [OW-1:0] LAST_OFF = OW'(LINE_WORDS - 1);
   typedef enum logic [1:0] {IDLE, REQ, FILL} state_t;
   state_t state;
   logic line_valid, flush_seen, hit, last_beat, unused;
   logic [TW-1:0] line_tag;
   logic [31:0] line_data [LINE_WORDS];
   logic [31:0] pend_addr;
   logic [OW:0] beat_cnt;
   logic [OW-1:0] req_off, pend_off;
   assign req_off = inst_sram_addr[OW+1:2];
   assign pend_off = pend_addr[OW+1:2];
   assign hit = line_valid && line_tag == inst_sram_addr[31:OW+2] && !flush;
   assign last_beat = mem_rd_valid && beat_cnt == LAST_BEAT;
   assign fetch_stall = state != IDLE;
   assign mem_rd_req = state == REQ;
   assign mem_rd_addr = {pend_addr[31:OW+2], {(OW + 2){1'b0}}};
   assign unused = ^{inst_sram_wen, inst_sram_wdata, inst_sram_addr[1:0], pend_addr[1:0]};
   always_ff @(posedge clk)
      if (state == FILL && mem_rd_valid) line_data[beat_cnt[OW-1:0]] <= mem_rd_data;
   always_ff @(posedge clk or negedge resetn)
      if (!resetn) begin
         state <= IDLE;
         line_valid <= 1'b0;
         line_tag <= '0;
         pend_addr <= '0;
         beat_cnt <= '0;
         flush_seen <= 1'b0;
         inst_sram_rdata <= '0;
      end else begin
         case (state)
            IDLE: begin
               flush_seen <= 1'b0;
               if (flush) line_valid <= 1'b0;
               if (inst_sram_en && hit) inst_sram_rdata <= line_data[req_off];
               else if (inst_sram_en) begin
                  pend_addr <= inst_sram_addr;
                  state <= REQ;
               end
            end
            REQ: begin
               if (flush) flush_seen <= 1'b1;
               if (mem_rd_ready) begin
                  beat_cnt <= '0;
                  state <= FILL;
               end
            end
            FILL: begin
               if (flush) flush_seen <= 1'b1;
               if (mem_rd_valid) beat_cnt <= beat_cnt + 1'b1;
               if (last_beat) begin
                  line_tag <= pend_addr[31:OW+2];
                  line_valid <= !(flush_seen || flush);
                  // the final beat is not in the array yet, so forward it directly
                  inst_sram_rdata <= pend_off == LAST_OFF ? mem_rd_data : line_data[pend_off];
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
endmodule

// File: tb/tb_inst_fetch_responder.sv
// tb_inst_fetch_responder: scoreboard bench for the fetch buffer; inputs driven and outputs
// sampled on the falling edge, expected fetch words queued when each request is issued.
module tb_inst_fetch_responder;
   localparam int LW = 4;
   logic clk = 0, resetn = 0, en = 0, flush = 0, rdy = 0, vld = 0;
   logic [3:0] wen = '0;
   logic [31:0] addr = '0, wdata = '0, rdat = '0;
   logic [31:0] rdata, raddr;
   logic stall, req;
   int checks = 0, failures = 0, stall_cnt = 0;
   logic [31:0] beats [LW];
   logic [31:0] exp_q [$];
   logic [31:0] exp;
   inst_fetch_responder #(.LINE_WORDS(LW)) dut (
      .clk(clk), .resetn(resetn), .inst_sram_en(en), .inst_sram_wen(wen),
      .inst_sram_addr(addr), .inst_sram_wdata(wdata), .inst_sram_rdata(rdata),
      .fetch_stall(stall), .flush(flush), .mem_rd_req(req), .mem_rd_addr(raddr),
      .mem_rd_ready(rdy), .mem_rd_valid(vld), .mem_rd_data(rdat)
   );
   always #5 clk = ~clk;
   always @(posedge clk) stall_cnt <= stall_cnt + int'(stall);
   always @(posedge clk)
      if (resetn) assert (!(en && stall)) else $error("protocol violation: en while fetch_stall");
   task automatic serve(input int rdy_delay, input int gap_at, input int flush_at, input int nbeats);
      int n = 0;
      while (!req && n < 100) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (req !== 1'b1) begin failures++; $display("FAIL serve_req: mem_rd_req=%b required 1", req); end
      repeat (rdy_delay) @(negedge clk);
      rdy = 1;
      @(negedge clk);
      rdy = 0;
      for (int b = 0; b < nbeats; b++) begin
         if (b == gap_at) @(negedge clk);
         vld = 1;
         rdat = beats[b];
         flush = (b == flush_at);
         @(negedge clk);
         vld = 0;
         flush = 0;
      end
   endtask
   task automatic test_reset;
      resetn = 0;
      repeat (3) @(negedge clk);
      checks += 4;
      if (rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata: got %h want 0", rdata); end
      if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall: got %b want 0", stall); end
      if (req !== 1'b0) begin failures++; $display("FAIL reset_req: got %b want 0", req); end
      if (raddr !== 32'h0) begin failures++; $display("FAIL reset_addr: got %h want 0", raddr); end
      resetn = 1;
      @(negedge clk);
      en = 1; addr = 32'hbfc00000; exp_q.push_back(32'ha0);
      @(negedge clk);
      en = 0;
      checks += 3;
      if (stall !== 1'b1) begin failures++; $display("FAIL first_stall: got %b want 1", stall); end
      if (req !== 1'b1) begin failures++; $display("FAIL first_req: got %b want 1", req); end
      if (raddr !== 32'hbfc00000) begin failures++; $display("FAIL first_addr: got %h want bfc00000", raddr); end
      beats = '{32'ha0, 32'ha1, 32'ha2, 32'ha3};
      serve(0, -1, -1, LW);
      exp = exp_q.pop_front();
      checks += 2;
      if (stall !== 1'b0) begin failures++; $display("FAIL first_done_stall: got %b want 0", stall); end
      if (rdata !== exp) begin failures++; $display("FAIL first_rdata: got %h want %h", rdata, exp); end
   endtask
   task automatic test_miss_fill;
      int s0;
      flush = 1;
      @(negedge clk);
      flush = 0;
      s0 = stall_cnt;
      en = 1; addr = 32'hbfc00008; exp_q.push_back(32'h33);
      @(negedge clk);
      en = 0;
      checks++;
      if (raddr !== 32'hbfc00000) begin failures++; $display("FAIL fill_addr: got %h want bfc00000", raddr); end
      beats = '{32'h11, 32'h22, 32'h33, 32'h44};
      serve(3, 2, -1, LW);
      exp = exp_q.pop_front();
      checks += 3;
      if (stall_cnt - s0 != 9) begin failures++; $display("FAIL fill_penalty: got %0d want 9", stall_cnt - s0); end
      if (stall !== 1'b0) begin failures++; $display("FAIL fill_stall: got %b want 0", stall); end
      if (rdata !== exp) begin failures++; $display("FAIL fill_rdata: got %h want %h", rdata, exp); end
   endtask
   task automatic test_seq_hits;
      logic [31:0] a [3] = '{32'hbfc00000, 32'hbfc00004, 32'hbfc0000c};
      logic [31:0] w [3] = '{32'h11, 32'h22, 32'h44};
      int s0 = stall_cnt;
      for (int i = 0; i < 3; i++) begin
         en = 1; addr = a[i]; exp_q.push_back(w[i]);
         @(negedge clk);
         exp = exp_q.pop_front();
         checks++;
         if (rdata !== exp) begin failures++; $display("FAIL hit_rdata[%0d]: got %h want %h", i, rdata, exp); end
      end
      en = 0;
      @(negedge clk);
      checks += 2;
      if (rdata !== 32'h44) begin failures++; $display("FAIL hit_hold: got %h want 44", rdata); end
      if (stall_cnt != s0) begin failures++; $display("FAIL hit_stall: stall cycles %0d want 0", stall_cnt - s0); end
   endtask
   task automatic test_flush_mid_fill;
      en = 1; addr = 32'h80001014; exp_q.push_back(32'h52);
      @(negedge clk);
      en = 0;
      beats = '{32'h51, 32'h52, 32'h53, 32'h54};
      serve(1, -1, 1, LW);
      exp = exp_q.pop_front();
      checks += 2;
      if (stall !== 1'b0) begin failures++; $display("FAIL flush_fill_stall: got %b want 0", stall); end
      if (rdata !== exp) begin failures++; $display("FAIL flush_fill_rdata: got %h want %h", rdata, exp); end
      en = 1; exp_q.push_back(32'h62);
      @(negedge clk);
      en = 0;
      checks++;
      if (req !== 1'b1) begin failures++; $display("FAIL flush_refetch_req: got %b want 1", req); end
      beats = '{32'h61, 32'h62, 32'h63, 32'h64};
      serve(0, -1, -1, LW);
      exp = exp_q.pop_front();
      checks++;
      if (rdata !== exp) begin failures++; $display("FAIL refetch_rdata: got %h want %h", rdata, exp); end
      en = 1; addr = 32'h8000101c; exp_q.push_back(32'h64);
      @(negedge clk);
      en = 0;
      exp = exp_q.pop_front();
      checks += 2;
      if (stall !== 1'b0) begin failures++; $display("FAIL clean_hit_stall: got %b want 0", stall); end
      if (rdata !== exp) begin failures++; $display("FAIL clean_hit_rdata: got %h want %h", rdata, exp); end
   endtask
   task automatic test_flush_en;
      int s0 = stall_cnt;
      en = 1; flush = 1; addr = 32'h8000101c; exp_q.push_back(32'h74);
      @(negedge clk);
      en = 0; flush = 0;
      checks += 2;
      if (req !== 1'b1) begin failures++; $display("FAIL flush_en_req: got %b want 1", req); end
      if (stall !== 1'b1) begin failures++; $display("FAIL flush_en_stall: got %b want 1", stall); end
      beats = '{32'h71, 32'h72, 32'h73, 32'h74};
      serve(0, -1, -1, LW);
      exp = exp_q.pop_front();
      checks += 2;
      if (stall_cnt - s0 != LW + 1) begin failures++; $display("FAIL min_penalty: got %0d want %0d", stall_cnt - s0, LW + 1); end
      if (rdata !== exp) begin failures++; $display("FAIL forward_rdata: got %h want %h", rdata, exp); end
   endtask
   task automatic test_reset_mid_fill;
      en = 1; addr = 32'h40000004;
      @(negedge clk);
      en = 0;
      beats = '{32'h81, 32'h82, 32'h83, 32'h84};
      serve(0, -1, -1, 2);
      resetn = 0;
      #1;
      checks += 3;
      if (stall !== 1'b0) begin failures++; $display("FAIL abort_stall: got %b want 0", stall); end
      if (rdata !== 32'h0) begin failures++; $display("FAIL abort_rdata: got %h want 0", rdata); end
      if (req !== 1'b0) begin failures++; $display("FAIL abort_req: got %b want 0", req); end
      @(negedge clk);
      resetn = 1;
      @(negedge clk);
      en = 1; addr = 32'h40000000; exp_q.push_back(32'h91);
      @(negedge clk);
      en = 0;
      checks++;
      if (req !== 1'b1) begin failures++; $display("FAIL abort_refetch_req: got %b want 1", req); end
      beats = '{32'h91, 32'h92, 32'h93, 32'h94};
      serve(2, -1, -1, LW);
      exp = exp_q.pop_front();
      checks += 2;
      if (stall !== 1'b0) begin failures++; $display("FAIL abort_refill_stall: got %b want 0", stall); end
      if (rdata !== exp) begin failures++; $display("FAIL abort_refill_rdata: got %h want %h", rdata, exp); end
   endtask
   initial begin
      test_reset;
      test_miss_fill;
      test_seq_hits;
      test_flush_mid_fill;
      test_flush_en;
      test_reset_mid_fill;
      checks++;
      if (exp_q.size() != 0) begin failures++; $display("FAIL scoreboard_drain: %0d left want 0", exp_q.size()); end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/inst_fetch_responder.md
# inst_fetch_responder

Responder end of the instruction SRAM-like port that the fetch stage drives. It accepts one-cycle `inst_sram_en`/`inst_sram_addr` requests and returns `inst_sram_rdata` one cycle later on a hit in a single-line fetch buffer. On a miss it asserts `fetch_stall`, which feeds the fetch-stage stall input, and refills the line from a variable-latency memory read channel. It sits between the fetch stage and the instruction-side memory bridge.

## Interface
- `LINE_WORDS`, default 4: words per buffered line; power of two, 2..8.
- `clk`  in  1  clock; all state updates on the rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `inst_sram_en`  in  1  request strobe; address is sampled on an edge where this is 1.
- `inst_sram_wen`  in  4  ignored; the port is read-only, so every request is a read.
- `inst_sram_addr`  in  32  byte address; bits [1:0] are ignored.
- `inst_sram_wdata`  in  32  unused.
- `inst_sram_rdata`  out  32  instruction word for the last accepted request.
- `fetch_stall`  out  1  high while the word for the last accepted request is not yet available.
- `flush`  in  1  invalidates the buffered line.
- `mem_rd_req`  out  1  line read request; held high until accepted.
- `mem_rd_addr`  out  32  line-aligned address, i.e. request address with bits [log2(LINE_WORDS)+1:0] = 0.
- `mem_rd_ready`  in  1  request accepted when `mem_rd_req` && `mem_rd_ready`.
- `mem_rd_valid`  in  1  one data beat is presented.
- `mem_rd_data`  in  32  beat data; beats arrive in ascending word order.

## Operation
- Storage: `line_valid`, a tag `line_tag` = addr[31:log2(LINE_WORDS)+2], and a `LINE_WORDS` x 32 data array.
- Word offset = addr[log2(LINE_WORDS)+1:2].
- Hit: `line_valid` && tag match && `flush`==0.
- FSM states: IDLE, REQ, FILL.
- IDLE, `inst_sram_en`=1:
  - On a hit: rdata register <= buffered word; stay IDLE.
  - On a miss: latch the address into `pend_addr`; go to REQ.
- IDLE, `inst_sram_en`=0: rdata holds its value; it changes only on an accepted request or on fill completion.
- REQ: `mem_rd_req`=1 with `mem_rd_addr`=line-aligned `pend_addr`. On `mem_rd_ready`=1, go to FILL and clear the beat counter.
- FILL: each `mem_rd_valid` beat writes data[beat_cnt] and increments `beat_cnt`. Width is log2(LINE_WORDS)+1 bits.
- FILL completion, on the beat where `beat_cnt`==LINE_WORDS-1:
  - `line_tag` <= tag of `pend_addr`.
  - `line_valid` <= 1, unless `flush` was seen at any time since the miss.
  - rdata register <= the word at the `pend_addr` offset; the final beat's data is forwarded if it is that word.
  - Go to IDLE.
- `fetch_stall` = (state != IDLE).
- `inst_sram_en` while `fetch_stall`=1 is a requester protocol violation: ignored, and flagged by a bench assertion.
- `flush` in IDLE clears `line_valid`. `flush` and `en` in the same cycle: the request is treated as a miss.
- `flush` in REQ/FILL: the fill completes and delivers the pending word, but the line is left invalid. A sticky `flush_seen` bit records this and is cleared on IDLE entry.
- `mem_rd_valid` outside FILL is ignored.

## Timing
- Reset (resetn=0, async): state=IDLE, `line_valid`=0, `fetch_stall`=0, `inst_sram_rdata`=0, `mem_rd_req`=0, `mem_rd_addr`=0, `beat_cnt`=0.
- Hit: en at edge N, rdata valid after N, `fetch_stall`=0 throughout; one-cycle latency.
- Miss: en at edge N.
  - `fetch_stall`=1 and `mem_rd_req`=1 after N.
  - Request accepted at edge R; beats sampled at edges; last beat at edge L.
  - After L: `fetch_stall`=0 and rdata valid.
  - Minimum miss penalty with ready=1 and back-to-back beats = LINE_WORDS+1 stall cycles.
- `mem_rd_addr` is stable for the whole of REQ.
- resetn low mid-REQ/FILL aborts the fill. The line is invalid afterward, and the memory side must tolerate the dropped transaction.

## Test plan
- Reset: hold resetn=0, then release → all outputs 0. A first fetch at 0xbfc00000 misses, `mem_rd_addr`=0xbfc00000, `fetch_stall`=1.
- Miss-fill: LINE_WORDS=4, en addr 0xbfc00008, ready after 3 cycles, beats 0x11,0x22,0x33,0x44 with one idle gap. Required: stall for 1+3+4+1 cycles, then rdata=0x33 and stall=0.
- Sequential hits: after the fill, en at 0xbfc00000, 0xbfc00004, 0xbfc0000c on consecutive edges → rdata 0x11, 0x22, 0x44 one cycle after each; stall never asserts.
- Flush mid-fill: pulse `flush` during FILL → pending word still delivered. The next en at the same address misses with a new `mem_rd_req`.
- Simultaneous flush+en in IDLE on a valid line → treated as a miss, `mem_rd_req`=1 next cycle.
- Reset mid-fill: resetn=0 after 2 beats → state IDLE, stall=0, rdata=0. A refetch of the same line misses.
